// File: rtl/mole_game_core.sv
// mole_game_core: whack-a-mole round controller with LFSR mole placement, saturating BCD score and BCD countdown
module mole_game_core #(
  parameter int          N_HOLES      = 16,
  parameter int          TICK_DIV     = 50000000,
  parameter int          MOLE_LIFE    = 25000000,
  parameter int          GAME_SECS    = 30,
  parameter int          SCORE_DIGITS = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_key_valid,
  input  logic [3:0]                i_key_code,
  output logic [1:0]                o_state,
  output logic                      o_mole_valid,
  output logic [3:0]                o_mole_pos,
  output logic [4*SCORE_DIGITS-1:0] o_score,
  output logic [7:0]                o_time_bcd,
  output logic                      o_hit,
  output logic                      o_miss,
  output logic                      o_game_over
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;
  localparam int SW = 4 * SCORE_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int LW = $clog2(MOLE_LIFE);
  localparam logic [7:0]    SECS_BCD  = {4'(GAME_SECS / 10), 4'(GAME_SECS % 10)};
  localparam logic [4:0]    NH        = 5'(N_HOLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LIFE_LAST = LW'(MOLE_LIFE - 1);

  state_t          state_q, state_d;
  logic            mole_valid_q, mole_valid_d;
  logic [3:0]      mole_pos_q, mole_pos_d;
  logic [SW-1:0]   score_q, score_d, score_inc;
  logic [7:0]      time_q, time_d, time_dec;
  logic            hit_q, hit_d, miss_q, miss_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [LW-1:0]   life_q, life_d;
  logic [4:0]      cand, cand_p1;
  logic [3:0]      spawn_pos;
  logic            carry, start_go, hit, expire, tick_end, final_tick, spawn;

  assign cand       = {1'b0, lfsr_q[3:0]} % NH;
  assign cand_p1    = cand + 5'd1;
  assign spawn_pos  = (cand[3:0] != mole_pos_q) ? cand[3:0] : (cand_p1 == NH) ? 4'd0 : cand_p1[3:0];
  assign time_dec   = (time_q[3:0] == 4'd0) ? {time_q[7:4] - 4'd1, 4'd9} : {time_q[7:4], time_q[3:0] - 4'd1};
  assign start_go   = (state_q != PLAY) && i_start;
  assign hit        = (state_q == PLAY) && i_key_valid && mole_valid_q && (i_key_code == mole_pos_q);
  assign expire     = (state_q == PLAY) && mole_valid_q && (life_q == LIFE_LAST);
  assign tick_end   = (state_q == PLAY) && (tick_q == TICK_LAST);
  assign final_tick = tick_end && (time_q == 8'h01);
  assign spawn      = start_go || ((state_q == PLAY) && !mole_valid_q && !final_tick);

  // BCD increment with ripple carry; an all-nines score holds instead of wrapping
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i+:4] == 4'd9) score_inc[4*i+:4] = 4'd0;
        else begin
          score_inc[4*i+:4] = score_q[4*i+:4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    if (carry) score_inc = score_q;
  end

  // next-state: round sequencing, hit/expiry resolution (hit wins), timer and spawning
  always_comb begin
    state_d      = state_q;
    mole_valid_d = mole_valid_q;
    mole_pos_d   = mole_pos_q;
    score_d      = score_q;
    time_d       = time_q;
    tick_d       = tick_q;
    life_d       = life_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    if (start_go) begin
      state_d = PLAY;
      score_d = '0;
      time_d  = SECS_BCD;
      tick_d  = '0;
    end else if (state_q == PLAY) begin
      tick_d = tick_end ? '0 : tick_q + 1'b1;
      if (tick_end) time_d = time_dec;
      if (hit) begin
        hit_d        = 1'b1;
        score_d      = score_inc;
        mole_valid_d = 1'b0;
      end else if (expire) begin
        miss_d       = 1'b1;
        mole_valid_d = 1'b0;
      end else if (mole_valid_q) life_d = life_q + 1'b1;
      if (final_tick) begin
        state_d      = OVER;
        mole_valid_d = 1'b0;
      end
    end
    if (spawn) begin
      mole_valid_d = 1'b1;
      mole_pos_d   = spawn_pos;
      life_d       = '0;
    end
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      mole_valid_q <= 1'b0;
      mole_pos_q   <= 4'd0;
      score_q      <= '0;
      time_q       <= SECS_BCD;
      tick_q       <= '0;
      life_q       <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      state_q      <= state_d;
      mole_valid_q <= mole_valid_d;
      mole_pos_q   <= mole_pos_d;
      score_q      <= score_d;
      time_q       <= time_d;
      tick_q       <= tick_d;
      life_q       <= life_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign o_state      = state_q;
  assign o_mole_valid = mole_valid_q;
  assign o_mole_pos   = mole_pos_q;
  assign o_score      = score_q;
  assign o_time_bcd   = time_q;
  assign o_hit        = hit_q;
  assign o_miss       = miss_q;
  assign o_game_over  = (state_q == OVER);
endmodule

// File: tb/tb_mole_game_core.sv
// tb_mole_game_core: two differently parametrised cores checked every cycle against a behavioural round model
module tb_mole_game_core;
  localparam int          P_N[2]    = '{16, 10};
  localparam int          P_TD[2]   = '{10, 4};
  localparam int          P_ML[2]   = '{4, 1000};
  localparam int          P_GS[2]   = '{3, 60};
  localparam logic [15:0] P_SEED[2] = '{16'hACE1, 16'h1234};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st[2], kv[2];
  logic [3:0] kc[2];
  logic [1:0] o_st[2];
  logic       o_mv[2], o_h[2], o_m[2], o_go[2];
  logic [3:0] o_pos[2];
  logic [7:0] o_sc[2], o_tm[2];
  int total = 0, bad = 0;
  bit arm = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mole_game_core #(
      .N_HOLES(P_N[g]), .TICK_DIV(P_TD[g]), .MOLE_LIFE(P_ML[g]),
      .GAME_SECS(P_GS[g]), .SCORE_DIGITS(2), .LFSR_SEED(P_SEED[g])
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(st[g]), .i_key_valid(kv[g]), .i_key_code(kc[g]),
      .o_state(o_st[g]), .o_mole_valid(o_mv[g]), .o_mole_pos(o_pos[g]), .o_score(o_sc[g]),
      .o_time_bcd(o_tm[g]), .o_hit(o_h[g]), .o_miss(o_m[g]), .o_game_over(o_go[g])
    );
  end

  // behavioural model: state as plain integers (elapsed cycles, mole age, score count)
  int          m_state[2], m_mv[2], m_pos[2], m_score[2], m_el[2], m_age[2], m_hit[2], m_miss[2];
  logic [15:0] m_lfsr[2];
  logic [15:0] ml;
  bit          m_was;

  function automatic int pick(logic [15:0] l, int prev, int n);
    int c = int'(l[3:0]) % n;
    return (c == prev) ? (c + 1) % n : c;
  endfunction

  function automatic int bcd(int v);
    return ((v / 10) % 10) * 16 + v % 10;
  endfunction

  function automatic int exp_time(int i);
    return bcd(m_state[i] == 1 ? P_GS[i] - m_el[i] / P_TD[i] : m_state[i] == 2 ? 0 : P_GS[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_state[i] = 0; m_mv[i] = 0; m_pos[i] = 0; m_score[i] = 0; m_el[i] = 0;
        m_age[i] = 0; m_hit[i] = 0; m_miss[i] = 0; m_lfsr[i] = P_SEED[i];
      end else begin
        ml = m_lfsr[i];
        m_lfsr[i] = (ml >> 1) ^ (ml[0] ? 16'hB400 : 16'h0000);
        m_hit[i] = 0;
        m_miss[i] = 0;
        if (m_state[i] != 1 && st[i]) begin
          m_state[i] = 1; m_score[i] = 0; m_el[i] = 0;
          m_pos[i] = pick(ml, m_pos[i], P_N[i]); m_mv[i] = 1; m_age[i] = 0;
        end else if (m_state[i] == 1) begin
          m_el[i]++;
          m_was = m_mv[i] != 0;
          if (kv[i] && m_mv[i] != 0 && int'(kc[i]) == m_pos[i]) begin
            m_hit[i] = 1; m_mv[i] = 0;
            if (m_score[i] < 99) m_score[i]++;
          end else if (m_mv[i] != 0) begin
            m_age[i]++;
            if (m_age[i] == P_ML[i]) begin m_miss[i] = 1; m_mv[i] = 0; end
          end
          if (m_el[i] == P_GS[i] * P_TD[i]) begin
            m_state[i] = 2; m_mv[i] = 0;
          end else if (!m_was) begin
            m_pos[i] = pick(ml, m_pos[i], P_N[i]); m_mv[i] = 1; m_age[i] = 0;
          end
        end
      end
    end
  end

  task automatic chk(string name, int i, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] at %0t: got %0h want %0h", name, i, $time, act, exp);
    end
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (arm) begin
      for (int i = 0; i < 2; i++) begin
        chk("state", i, int'(o_st[i]), m_state[i]);
        chk("mole_valid", i, int'(o_mv[i]), m_mv[i]);
        chk("mole_pos", i, int'(o_pos[i]), m_pos[i]);
        chk("score", i, int'(o_sc[i]), bcd(m_score[i]));
        chk("time", i, int'(o_tm[i]), exp_time(i));
        chk("hit", i, int'(o_h[i]), m_hit[i]);
        chk("miss", i, int'(o_m[i]), m_miss[i]);
        chk("game_over", i, int'(o_go[i]), m_state[i] == 2 ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    st[0] = 1'b0; st[1] = 1'b0; kv[0] = 1'b0; kv[1] = 1'b0;
  endtask

  initial begin
    int prev, h, guard;
    bit pressed;
    st[0] = 1'b0; st[1] = 1'b0; kv[0] = 1'b0; kv[1] = 1'b0; kc[0] = 4'd0; kc[1] = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 0, int'(o_st[0]), 0);
    chk("rst_time", 0, int'(o_tm[0]), 'h03);
    chk("rst_time", 1, int'(o_tm[1]), 'h60);
    chk("rst_score", 0, int'(o_sc[0]), 0);
    chk("rst_mv", 0, int'(o_mv[0]), 0);
    chk("rst_pos", 0, int'(o_pos[0]), 0);
    chk("rst_go", 0, int'(o_go[0]), 0);
    rst_n = 1'b1;
    arm = 1'b1;
    // key during IDLE
    kv[0] = 1'b1; kc[0] = 4'd0; tick();
    chk("idle_key_hit", 0, int'(o_h[0]), 0);
    // full round with no keys
    st[0] = 1'b1; tick();
    chk("start_state", 0, int'(o_st[0]), 1);
    chk("start_time", 0, int'(o_tm[0]), 'h03);
    chk("start_mv", 0, int'(o_mv[0]), 1);
    repeat (4) tick();
    chk("expire_miss", 0, int'(o_m[0]), 1);
    chk("expire_mv", 0, int'(o_mv[0]), 0);
    tick();
    chk("respawn_mv", 0, int'(o_mv[0]), 1);
    repeat (5) tick();
    chk("t10_time", 0, int'(o_tm[0]), 'h02);
    repeat (10) tick();
    chk("t20_time", 0, int'(o_tm[0]), 'h01);
    repeat (10) tick();
    chk("t30_time", 0, int'(o_tm[0]), 'h00);
    chk("t30_state", 0, int'(o_st[0]), 2);
    chk("t30_go", 0, int'(o_go[0]), 1);
    chk("t30_score", 0, int'(o_sc[0]), 0);
    // key during OVER
    kv[0] = 1'b1; kc[0] = 4'(m_pos[0]); tick();
    chk("over_key_hit", 0, int'(o_h[0]), 0);
    // restart from OVER with a simultaneous key
    st[0] = 1'b1; kv[0] = 1'b1; kc[0] = 4'(m_pos[0]); tick();
    chk("restart_state", 0, int'(o_st[0]), 1);
    chk("restart_time", 0, int'(o_tm[0]), 'h03);
    chk("restart_hit", 0, int'(o_h[0]), 0);
    kv[0] = 1'b1; kc[0] = 4'(m_pos[0]); prev = m_pos[0]; tick();
    chk("hit_pulse", 0, int'(o_h[0]), 1);
    chk("hit_score", 0, int'(o_sc[0]), 'h01);
    chk("hit_mv", 0, int'(o_mv[0]), 0);
    kv[0] = 1'b1; kc[0] = 4'(prev); tick();
    chk("nomole_hit", 0, int'(o_h[0]), 0);
    chk("nomole_score", 0, int'(o_sc[0]), 'h01);
    chk("newpos_differs", 0, int'(o_pos[0] != 4'(prev)), 1);
    kv[0] = 1'b1; kc[0] = 4'((m_pos[0] + 1) % 16); tick();
    chk("wrong_hit", 0, int'(o_h[0]), 0);
    chk("wrong_score", 0, int'(o_sc[0]), 'h01);
    // asynchronous reset mid-round
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_state", 0, int'(o_st[0]), 0);
    chk("arst_score", 0, int'(o_sc[0]), 0);
    chk("arst_time", 0, int'(o_tm[0]), 'h03);
    chk("arst_mv", 0, int'(o_mv[0]), 0);
    chk("arst_pos", 0, int'(o_pos[0]), 0);
    tick();
    rst_n = 1'b1;
    // long-lived moles: hit continuously to reach saturation
    st[1] = 1'b1; tick();
    chk("i1_start_time", 1, int'(o_tm[1]), 'h60);
    h = 0;
    guard = 0;
    while (m_state[1] == 1 && guard < 400) begin
      pressed = m_mv[1] != 0;
      if (pressed) begin kv[1] = 1'b1; kc[1] = 4'(m_pos[1]); end
      tick();
      if (pressed) begin
        h++;
        if (h == 10) chk("score_carry", 1, int'(o_sc[1]), 'h10);
        if (h == 99) chk("score_99", 1, int'(o_sc[1]), 'h99);
        if (h == 100) begin
          chk("sat_hit", 1, int'(o_h[1]), 1);
          chk("sat_score", 1, int'(o_sc[1]), 'h99);
        end
      end
      guard++;
    end
    chk("i1_over", 1, int'(o_st[1]), 2);
    // hit on the final tick
    st[1] = 1'b1; tick();
    chk("i1_restart_score", 1, int'(o_sc[1]), 0);
    chk("i1_restart_time", 1, int'(o_tm[1]), 'h60);
    repeat (239) tick();
    chk("pre_final_time", 1, int'(o_tm[1]), 'h01);
    kv[1] = 1'b1; kc[1] = 4'(m_pos[1]); tick();
    chk("final_hit", 1, int'(o_h[1]), 1);
    chk("final_score", 1, int'(o_sc[1]), 'h01);
    chk("final_state", 1, int'(o_st[1]), 2);
    chk("final_time", 1, int'(o_tm[1]), 'h00);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        st[i] = (m_state[i] != 1) ? ($urandom % 20 == 0) : ($urandom % 50 == 0);
        kv[i] = ($urandom % 3 == 0);
        kc[i] = ($urandom % 2 == 0) ? 4'(m_pos[i]) : 4'($urandom % 16);
      end
      tick();
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
